fp_mult_arbiter: RTL

FP_MULT_ARBITER -- requirements
Module: fp_mult_arbiter

---
 rtl/fp_mult_arbiter.sv | 104 ++++++++++
 1 files changed

// File: rtl/fp_mult_arbiter.sv
// Two-requester arbiter in front of one shared combinational FP multiplier.
// Round-robin tie-break, one operation in flight, registered response with hold-until-accepted.
module fp_mult_arbiter #(
   parameter int OVF_CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req0_valid,
   input  logic [31:0]          req0_a,
   input  logic [31:0]          req0_b,
   output logic                 req0_ready,
   input  logic                 req1_valid,
   input  logic [31:0]          req1_a,
   input  logic [31:0]          req1_b,
   output logic                 req1_ready,
   output logic [31:0]          mul_a,
   output logic [31:0]          mul_b,
   input  logic [31:0]          mul_result,
   input  logic                 mul_overflow,
   output logic                 resp_valid,
   output logic                 resp_id,
   output logic [31:0]          resp_result,
   output logic                 resp_overflow,
   input  logic                 resp_ready,
   output logic                 busy,
   output logic [OVF_CNT_W-1:0] ovf_count
);

   typedef enum logic [1:0] {IDLE, MUL, RESP} state_t;

   state_t               r_state;
   logic                 r_prio;
   logic                 r_owner;
   logic [31:0]          r_mul_a;
   logic [31:0]          r_mul_b;
   logic                 r_resp_valid;
   logic                 r_resp_id;
   logic [31:0]          r_resp_result;
   logic                 r_resp_overflow;
   logic [OVF_CNT_W-1:0] r_ovf_count;

   logic w_grant;
   logic w_grant_id;

   // A lone requester wins outright; the priority pointer only breaks ties.
   assign w_grant_id = (req0_valid & req1_valid) ? r_prio : req1_valid;
   assign w_grant    = (r_state == IDLE) & (req0_valid | req1_valid) & ~rst;

   assign req0_ready    = w_grant & ~w_grant_id;
   assign req1_ready    = w_grant &  w_grant_id;
   assign busy          = (r_state != IDLE) & ~rst;
   assign mul_a         = r_mul_a;
   assign mul_b         = r_mul_b;
   assign resp_valid    = r_resp_valid;
   assign resp_id       = r_resp_id;
   assign resp_result   = r_resp_result;
   assign resp_overflow = r_resp_overflow;
   assign ovf_count     = r_ovf_count;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state         <= IDLE;
         r_prio          <= 1'b0;
         r_owner         <= 1'b0;
         r_mul_a         <= '0;
         r_mul_b         <= '0;
         r_resp_valid    <= 1'b0;
         r_resp_id       <= 1'b0;
         r_resp_result   <= '0;
         r_resp_overflow <= 1'b0;
         r_ovf_count     <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_grant) begin
                  r_mul_a <= w_grant_id ? req1_a : req0_a;
                  r_mul_b <= w_grant_id ? req1_b : req0_b;
                  r_owner <= w_grant_id;
                  r_state <= MUL;
               end
            end
            MUL: begin
               r_resp_result   <= mul_result;
               r_resp_overflow <= mul_overflow;
               r_resp_id       <= r_owner;
               r_resp_valid    <= 1'b1;
               r_state         <= RESP;
               if (mul_overflow && (r_ovf_count != {OVF_CNT_W{1'b1}}))
                  r_ovf_count <= r_ovf_count + 1'b1;
            end
            RESP: begin
               // The requester just served loses the next tie.
               if (resp_ready) begin
                  r_resp_valid <= 1'b0;
                  r_prio       <= ~r_owner;
                  r_state      <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule
